// File: rtl/prgmem_ila_if.sv
// Probe, trigger-setup, readout and status bundle for the program-memory ILA.
interface prgmem_ila_if #(
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   probe0;
    logic [7:0]    probe1;
    logic          arm;
    logic [7:0]    trig_value;
    logic [7:0]    trig_mask;
    logic [AW-1:0] rd_addr;
    logic [39:0]   rd_data;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [AW:0]   sample_count;
    logic [AW-1:0] trig_index;

    // Probe source and readout consumer
    modport master (
        output probe0, probe1, arm, trig_value, trig_mask, rd_addr,
        input  rd_data, armed, triggered, done, sample_count, trig_index
    );

    // Analyzer core
    modport slave (
        input  probe0, probe1, arm, trig_value, trig_mask, rd_addr,
        output rd_data, armed, triggered, done, sample_count, trig_index
    );
endinterface

// File: rtl/prgmem_ila.sv
// Trigger-and-capture logic analyzer: circular sample buffer that freezes a
// fixed number of samples after an address-probe trigger match.
module prgmem_ila #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned POST_SAMPLES = 128
) (
    input  logic         clk,
    input  logic         reset,
    prgmem_ila_if.slave  bus
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned POST_LAST = (POST_SAMPLES == 0) ? 0 : POST_SAMPLES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] tptr_q, tptr_d;
    logic [AW-1:0] post_q, post_d;
    logic [39:0]   rd_data_q;

    logic [39:0]   mem [DEPTH];

    logic          hit_c;
    logic          we_c;
    logic [AW-1:0] start_c;
    logic [AW-1:0] raddr_c;

    // Masked trigger compare on the address probe
    assign hit_c = ((bus.probe1 ^ bus.trig_value) & bus.trig_mask) == 8'h00;

    // Oldest valid sample sits at the write pointer once the buffer has wrapped
    assign start_c = (wcnt_q == CW'(DEPTH)) ? wptr_q : '0;
    assign raddr_c = start_c + bus.rd_addr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arm overrides trigger and post-count completion
    always_comb begin
        state_d = state_q;
        if (bus.arm) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (hit_c) begin
                        state_d = (POST_SAMPLES == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (post_q == AW'(POST_LAST)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Capture datapath controls: write enable, pointers, counts
    always_comb begin
        we_c   = 1'b0;
        wptr_d = wptr_q;
        wcnt_d = wcnt_q;
        tptr_d = tptr_q;
        post_d = post_q;
        if (bus.arm) begin
            wptr_d = '0;
            wcnt_d = '0;
            tptr_d = '0;
            post_d = '0;
        end else if (state_q == S_WAIT || state_q == S_POST) begin
            we_c   = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (wcnt_q != CW'(DEPTH)) begin
                wcnt_d = wcnt_q + CW'(1);
            end
            if (state_q == S_WAIT && hit_c) begin
                tptr_d = wptr_q;
                post_d = '0;
            end
            if (state_q == S_POST) begin
                post_d = post_q + AW'(1);
            end
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            wcnt_q <= '0;
            tptr_q <= '0;
            post_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            wcnt_q <= wcnt_d;
            tptr_q <= tptr_d;
            post_q <= post_d;
        end
    end

    // Sample buffer write; contents survive reset
    always_ff @(posedge clk) begin
        if (we_c && !reset) begin
            mem[wptr_q] <= {bus.probe1, bus.probe0};
        end
    end

    // Registered read-first readout
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[raddr_c];
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.armed        = (state_q == S_WAIT);
    assign bus.triggered    = (state_q == S_POST);
    assign bus.done         = (state_q == S_DONE);
    assign bus.sample_count = wcnt_q;
    assign bus.trig_index   = tptr_q - start_c;
endmodule

// File: tb/tb_prgmem_ila.sv
// Directed bench for prgmem_ila with DEPTH=16, POST_SAMPLES=4.
module tb_prgmem_ila;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned POST  = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   n;

    prgmem_ila_if #(.DEPTH(DEPTH)) bus ();

    prgmem_ila #(.DEPTH(DEPTH), .POST_SAMPLES(POST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  tv;
        logic [7:0]  tm;
        int          last_n;
        int          cnt;
        int          tidx;
        int          raddr;
        logic [39:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_n();
        bus.probe0 = 32'(n);
        bus.probe1 = 8'(n);
    endtask

    // Pulse arm for one edge, then present n=0 for the first sampled edge
    task automatic arm_start(input logic [7:0] tv, input logic [7:0] tm);
        bus.trig_value = tv;
        bus.trig_mask  = tm;
        bus.arm        = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        n = 0;
        drive_n();
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                return;
            end
            n++;
            drive_n();
        end
    endtask

    task automatic run_until_trig(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.triggered) begin
                ok = 1'b1;
                return;
            end
            n++;
            drive_n();
        end
    endtask

    initial begin
        bit ok;
        tests = 0;
        fails = 0;
        n     = 0;

        vecs[0] = '{tv: 8'h20, tm: 8'hFF, last_n: 36, cnt: 16, tidx: 11, raddr: 0,  exp_rd: 40'h15_0000_0015};
        vecs[1] = '{tv: 8'h20, tm: 8'hFF, last_n: 36, cnt: 16, tidx: 11, raddr: 11, exp_rd: 40'h20_0000_0020};
        vecs[2] = '{tv: 8'h20, tm: 8'hFF, last_n: 36, cnt: 16, tidx: 11, raddr: 15, exp_rd: 40'h24_0000_0024};
        vecs[3] = '{tv: 8'h00, tm: 8'h00, last_n: 4,  cnt: 5,  tidx: 0,  raddr: 4,  exp_rd: 40'h04_0000_0004};
        vecs[4] = '{tv: 8'h35, tm: 8'h0F, last_n: 9,  cnt: 10, tidx: 5,  raddr: 5,  exp_rd: 40'h05_0000_0005};
        vecs[5] = '{tv: 8'h35, tm: 8'h0F, last_n: 9,  cnt: 10, tidx: 5,  raddr: 0,  exp_rd: 40'h00_0000_0000};

        reset          = 1'b1;
        bus.arm        = 1'b0;
        bus.probe0     = '0;
        bus.probe1     = '0;
        bus.trig_value = '0;
        bus.trig_mask  = '0;
        bus.rd_addr    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_armed",     64'(bus.armed),        64'd0);
        check("reset_triggered", 64'(bus.triggered),    64'd0);
        check("reset_done",      64'(bus.done),         64'd0);
        check("reset_count",     64'(bus.sample_count), 64'd0);
        check("reset_tidx",      64'(bus.trig_index),   64'd0);
        check("reset_rd_data",   64'(bus.rd_data),      64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven captures with readback
        for (int v = 0; v < 6; v++) begin
            arm_start(vecs[v].tv, vecs[v].tm);
            run_until_done(200, ok);
            check($sformatf("v%0d_done", v),   64'(ok),                64'd1);
            check($sformatf("v%0d_last_n", v), 64'(n),                 64'(vecs[v].last_n));
            check($sformatf("v%0d_count", v),  64'(bus.sample_count),  64'(vecs[v].cnt));
            check($sformatf("v%0d_tidx", v),   64'(bus.trig_index),    64'(vecs[v].tidx));
            bus.rd_addr = AW'(vecs[v].raddr);
            @(negedge clk);
            check($sformatf("v%0d_rd_data", v), 64'(bus.rd_data),      64'(vecs[v].exp_rd));
            check($sformatf("v%0d_frozen", v),  64'(bus.done),         64'd1);
        end

        // Re-arm one cycle after the trigger
        arm_start(8'h03, 8'hFF);
        run_until_trig(100, ok);
        check("rearm_trig_seen", 64'(ok), 64'd1);
        check("rearm_trig_n",    64'(n),  64'd3);
        arm_start(8'h03, 8'hFF);
        check("rearm_triggered", 64'(bus.triggered),    64'd0);
        check("rearm_armed",     64'(bus.armed),        64'd1);
        check("rearm_count0",    64'(bus.sample_count), 64'd0);
        @(negedge clk);
        check("rearm_count1",    64'(bus.sample_count), 64'd1);
        n++;
        drive_n();
        run_until_done(100, ok);
        check("rearm_done",   64'(ok),               64'd1);
        check("rearm_last_n", 64'(n),                64'd7);
        check("rearm_count",  64'(bus.sample_count), 64'd8);
        check("rearm_tidx",   64'(bus.trig_index),   64'd3);

        // Reset two cycles after the trigger
        arm_start(8'h03, 8'hFF);
        run_until_trig(100, ok);
        check("rst_trig_seen", 64'(ok), 64'd1);
        n++;
        drive_n();
        @(negedge clk);
        check("rst_still_post", 64'(bus.triggered), 64'd1);
        reset = 1'b1;
        n++;
        drive_n();
        @(negedge clk);
        check("rst_armed",     64'(bus.armed),        64'd0);
        check("rst_triggered", 64'(bus.triggered),    64'd0);
        check("rst_done",      64'(bus.done),         64'd0);
        check("rst_count",     64'(bus.sample_count), 64'd0);
        check("rst_tidx",      64'(bus.trig_index),   64'd0);
        check("rst_rd_data",   64'(bus.rd_data),      64'd0);
        reset = 1'b0;
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 10; i++) begin
                n++;
                drive_n();
                @(negedge clk);
                if (bus.done || bus.armed || bus.triggered) done_seen++;
            end
            check("rst_stays_idle", 64'(done_seen), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
